// File: rtl/ram8_fifo_ctrl.sv
// ram8_fifo_ctrl: turns the single-port 8x16 RAM8 block into a synchronous FIFO.
// Pop has priority over push because the RAM has only one port.
// Read data returns one cycle after an accepted pop, with a registered valid strobe.
module ram8_fifo_ctrl #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  output logic          push_ready,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic          pop_valid,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          ovf_err,
  output logic          unf_err,
  output logic          ram_e,
  output logic          ram_w,
  output logic          ram_r,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  localparam int unsigned DEPTH    = 2 ** AW;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW + 1)'(1);
  localparam logic [AW-1:0] ONE_PTR = AW'(1);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop_acc;
  logic          push_acc;

  // Flags decode only from the registered count
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // Read data is a straight passthrough of the RAM output register
  assign pop_data = ram_dout;

  // Accept decisions and RAM drive; strobes held low while in reset
  always_comb begin
    pop_acc    = 1'b0;
    push_acc   = 1'b0;
    push_ready = 1'b0;
    ram_e      = 1'b0;
    ram_w      = 1'b0;
    ram_r      = 1'b0;
    ram_addr   = wr_ptr;
    ram_din    = push_data;

    pop_acc    = pop & ~empty;
    push_ready = ~full & ~pop_acc;
    push_acc   = push & push_ready;

    if (pop_acc) begin
      ram_addr = rd_ptr;
    end

    ram_r = pop_acc & rst_n;
    ram_w = push_acc & rst_n;
    ram_e = (pop_acc | push_acc) & rst_n;
  end

  // Pointers, occupancy, read-valid strobe and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pop_valid <= 1'b0;
      ovf_err   <= 1'b0;
      unf_err   <= 1'b0;
    end else begin
      pop_valid <= pop_acc;
      if (push_acc) begin
        wr_ptr <= wr_ptr + ONE_PTR;
        count  <= count + ONE_CNT;
      end else if (pop_acc) begin
        rd_ptr <= rd_ptr + ONE_PTR;
        count  <= count - ONE_CNT;
      end
      if (push && full) begin
        ovf_err <= 1'b1;
      end
      if (pop && empty) begin
        unf_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ram8_fifo_ctrl.sv
// tb_ram8_fifo_ctrl: directed plus randomized checks of ram8_fifo_ctrl against a
// queue-based FIFO model, with a behavioural RAM8 attached to the RAM port.
module tb_ram8_fifo_ctrl;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 3;
  localparam int unsigned DEPTH = 8;

  logic          clk;
  logic          rst_n;
  logic          push;
  logic [DW-1:0] push_data;
  logic          push_ready;
  logic          pop;
  logic [DW-1:0] pop_data;
  logic          pop_valid;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          ovf_err;
  logic          unf_err;
  logic          ram_e;
  logic          ram_w;
  logic          ram_r;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  ram8_fifo_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_data  (push_data),
    .push_ready (push_ready),
    .pop        (pop),
    .pop_data   (pop_data),
    .pop_valid  (pop_valid),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .ovf_err    (ovf_err),
    .unf_err    (unf_err),
    .ram_e      (ram_e),
    .ram_w      (ram_w),
    .ram_r      (ram_r),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout)
  );

  // Behavioural RAM8: synchronous write, registered read
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_e && ram_w) mem[ram_addr] <= ram_din;
    if (ram_e && ram_r) ram_dout <= mem[ram_addr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [DW-1:0] q[$];
  int unsigned   n_push;
  int unsigned   n_pop;
  logic          m_valid;
  logic [DW-1:0] m_pdata;
  logic          m_ovf;
  logic          m_unf;

  int ncmp = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    n_push  = 0;
    n_pop   = 0;
    m_valid = 1'b0;
    m_pdata = '0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
  endtask

  // One clock cycle: drive, check all outputs against the model, clock, advance the model
  task automatic step(input logic p, input logic [DW-1:0] d, input logic r);
    logic m_full, m_empty, m_pacc, m_ready, m_wacc;
    push = p; push_data = d; pop = r;
    #1;
    m_full  = (q.size() == DEPTH);
    m_empty = (q.size() == 0);
    m_pacc  = r && !m_empty;
    m_ready = !m_full && !m_pacc;
    m_wacc  = p && m_ready;
    chk("count",      32'(count),      32'(q.size()));
    chk("full",       32'(full),       32'(m_full));
    chk("empty",      32'(empty),      32'(m_empty));
    chk("push_ready", 32'(push_ready), 32'(m_ready));
    chk("ram_r",      32'(ram_r),      32'(m_pacc));
    chk("ram_w",      32'(ram_w),      32'(m_wacc));
    chk("ram_e",      32'(ram_e),      32'(m_pacc || m_wacc));
    if (m_pacc || m_wacc)
      chk("ram_addr", 32'(ram_addr), m_pacc ? (n_pop % DEPTH) : (n_push % DEPTH));
    if (m_wacc) chk("ram_din", 32'(ram_din), 32'(d));
    chk("pop_valid",  32'(pop_valid),  32'(m_valid));
    if (m_valid) chk("pop_data", 32'(pop_data), 32'(m_pdata));
    chk("ovf_err",    32'(ovf_err),    32'(m_ovf));
    chk("unf_err",    32'(unf_err),    32'(m_unf));
    @(posedge clk);
    #1;
    if (p && m_full)  m_ovf = 1'b1;
    if (r && m_empty) m_unf = 1'b1;
    m_valid = m_pacc;
    if (m_pacc) begin
      m_pdata = q.pop_front();
      n_pop++;
    end
    if (m_wacc) begin
      q.push_back(d);
      n_push++;
    end
  endtask

  // Asynchronous reset assertion mid-cycle with push held high
  task automatic do_reset();
    push = 1'b1; pop = 1'b0; push_data = 16'hDEAD;
    rst_n = 1'b0;
    #1;
    chk("rst_pop_valid", 32'(pop_valid), 32'(0));
    chk("rst_count",     32'(count),     32'(0));
    chk("rst_empty",     32'(empty),     32'(1));
    chk("rst_full",      32'(full),      32'(0));
    chk("rst_ovf",       32'(ovf_err),   32'(0));
    chk("rst_unf",       32'(unf_err),   32'(0));
    chk("rst_ram_e",     32'(ram_e),     32'(0));
    chk("rst_ram_w",     32'(ram_w),     32'(0));
    @(posedge clk);
    #1;
    push = 1'b0;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic p, r;
    push = 1'b0; pop = 1'b0; push_data = '0; ram_dout = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state, then fill with 1..8
    step(1'b0, 16'h0, 1'b0);
    for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), 1'b0);
    // Overflow attempt, then confirm nothing changed
    step(1'b1, 16'h9, 1'b0);
    step(1'b0, 16'h0, 1'b0);
    // Drain 8 back-to-back, then observe the last word
    for (int i = 0; i < 8; i++) step(1'b0, 16'h0, 1'b1);
    step(1'b0, 16'h0, 1'b0);
    // Underflow attempt
    step(1'b0, 16'h0, 1'b1);
    step(1'b0, 16'h0, 1'b0);

    // Wrap: 5 in, 5 out, then 0xA0..0xA5 land at 5,6,7,0,1,2
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, DW'(16'h10 + i), 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, DW'(16'hA0 + i), 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 16'h0, 1'b1);
    step(1'b0, 16'h0, 1'b0);

    // Push and pop together at count 3: pop wins, push lands next cycle
    for (int i = 0; i < 3; i++) step(1'b1, DW'(16'h30 + i), 1'b0);
    step(1'b1, 16'h55, 1'b1);
    step(1'b1, 16'h55, 1'b0);
    chk("simul_count", 32'(count), 32'(3));
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b1);

    // Reset one cycle after an accepted pop drops the pending valid
    do_reset();
    step(1'b0, 16'h0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      p = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 70 : 35));
      r = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 35 : 70));
      step(p, DW'($urandom), r);
    end
    step(1'b0, 16'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
